phase_rotate_pipe: RTL and testbench

PHASE_ROTATE_PIPE -- requirements
Module: phase_rotate_pipe

---
 rtl/phase_pkg.sv | 16 +
 rtl/phase_rot_stage.sv | 30 +++
 rtl/phase_rotate_pipe.sv | 126 ++++++++++++
 tb/tb_phase_rotate_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared types and helpers for the per-lane phase rotation pipeline.
package phase_pkg;

    typedef enum logic [1:0] {
        ROR    = 2'd0,
        ROL    = 2'd1,
        SHR    = 2'd2,
        BYPASS = 2'd3
    } phase_mode_t;

    // Barrel levels handled by the first pipeline stage; the rest go to stage 2.
    function automatic int stage1_levels(input int kw);
        return (kw + 1) / 2;
    endfunction

endpackage

// File: rtl/phase_rot_stage.sv
// One combinational group of right-rotate barrel levels for a single lane.
// With shr set, each level masks off the wrapped bits to give a zero-fill shift.
module phase_rot_stage #(
    parameter int BITSTREAM = 64,
    parameter int LVL_OFF   = 0,
    parameter int LVL_CNT   = 1
) (
    input  logic [BITSTREAM-1:0] bits_in,
    input  logic [LVL_CNT-1:0]   amt,
    input  logic                 shr,
    output logic [BITSTREAM-1:0] bits_out
);

    logic [BITSTREAM-1:0] chain [LVL_CNT+1];

    assign chain[0] = bits_in;

    for (genvar g = 0; g < LVL_CNT; g++) begin : g_lvl
        localparam int SH = 1 << (LVL_OFF + g);
        localparam logic [BITSTREAM-1:0] FILL_MASK = {BITSTREAM{1'b1}} >> SH;

        logic [BITSTREAM-1:0] rot;

        assign rot          = (chain[g] >> SH) | (chain[g] << (BITSTREAM - SH));
        assign chain[g + 1] = amt[g] ? (shr ? (rot & FILL_MASK) : rot) : chain[g];
    end

    assign bits_out = chain[LVL_CNT];

endmodule

// File: rtl/phase_rotate_pipe.sv
// Two-stage, backpressured per-lane rotate/shift pipeline (ROR, ROL, SHR, BYPASS).
// Every mode is reduced to a right rotate amount; SHR masks the wrapped bits.
module phase_rotate_pipe
    import phase_pkg::*;
#(
    parameter int BITSTREAM = 64,
    parameter int CHANNELS  = 4,
    parameter int KW        = $clog2(BITSTREAM)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_mode,
    input  logic [CHANNELS*KW-1:0]        in_k,
    input  logic [CHANNELS*BITSTREAM-1:0] in_bits,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHANNELS*BITSTREAM-1:0] out_bits,
    output logic [1:0]                    out_mode
);

    localparam int L1 = stage1_levels(KW);
    localparam int L2 = KW - L1;
    localparam int CW = CHANNELS * BITSTREAM;

    phase_mode_t           mode_in;
    logic                  shr_p0;
    logic [CW-1:0]         bits_s1;
    logic [CHANNELS*L2-1:0] amt_hi_s0;

    logic                  vld_p1;
    phase_mode_t           mode_p1;
    logic [CW-1:0]         bits_p1;
    logic [CHANNELS*L2-1:0] amt_hi_p1;
    logic                  shr_p1;
    logic [CW-1:0]         bits_s2;

    logic                  vld_p2;
    phase_mode_t           mode_p2;
    logic [CW-1:0]         bits_p2;

    logic                  adv1;
    logic                  adv2;

    assign mode_in = phase_mode_t'(in_mode);
    assign shr_p0  = (mode_in == SHR);
    assign shr_p1  = (mode_p1 == SHR);

    // A stage loads when it is empty or its successor is taking its beat.
    assign adv2     = !vld_p2 || out_ready;
    assign adv1     = !vld_p1 || adv2;
    assign in_ready = adv1;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [KW-1:0] k_c;
        logic [KW-1:0] amt_c;

        assign k_c = in_k[c*KW +: KW];

        always_comb begin
            amt_c = k_c;
            case (mode_in)
                ROL:     amt_c = ~k_c + KW'(1);
                BYPASS:  amt_c = '0;
                default: amt_c = k_c;
            endcase
        end

        assign amt_hi_s0[c*L2 +: L2] = amt_c[KW-1:L1];

        phase_rot_stage #(
            .BITSTREAM (BITSTREAM),
            .LVL_OFF   (0),
            .LVL_CNT   (L1)
        ) u_rot_lo (
            .bits_in  (in_bits[c*BITSTREAM +: BITSTREAM]),
            .amt      (amt_c[L1-1:0]),
            .shr      (shr_p0),
            .bits_out (bits_s1[c*BITSTREAM +: BITSTREAM])
        );

        phase_rot_stage #(
            .BITSTREAM (BITSTREAM),
            .LVL_OFF   (L1),
            .LVL_CNT   (L2)
        ) u_rot_hi (
            .bits_in  (bits_p1[c*BITSTREAM +: BITSTREAM]),
            .amt      (amt_hi_p1[c*L2 +: L2]),
            .shr      (shr_p1),
            .bits_out (bits_s2[c*BITSTREAM +: BITSTREAM])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (adv1) vld_p1 <= in_valid;
            if (adv2) vld_p2 <= vld_p1;
        end
    end

    // Stage 1 boundary: low levels applied, high amount bits carried forward.
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            bits_p1   <= bits_s1;
            amt_hi_p1 <= amt_hi_s0;
            mode_p1   <= mode_in;
        end
    end

    // Stage 2 boundary: fully rotated result held until downstream accepts it.
    always_ff @(posedge clk) begin
        if (adv2 && vld_p1) begin
            bits_p2 <= bits_s2;
            mode_p2 <= mode_p1;
        end
    end

    assign out_valid = vld_p2;
    assign out_bits  = vld_p2 ? bits_p2 : '0;
    assign out_mode  = vld_p2 ? mode_p2 : 2'b00;

endmodule

// File: tb/tb_phase_rotate_pipe.sv
// Scoreboard bench for phase_rotate_pipe: directed scenarios, backpressure, reset, random sweep.
module tb_phase_rotate_pipe;

    localparam int BITSTREAM = 64;
    localparam int CHANNELS  = 4;
    localparam int KW        = 6;
    localparam int W         = CHANNELS * BITSTREAM;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [1:0]             in_mode = 2'd0;
    logic [CHANNELS*KW-1:0] in_k = '0;
    logic [W-1:0]           in_bits = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [W-1:0]           out_bits;
    logic [1:0]             out_mode;

    phase_rotate_pipe #(
        .BITSTREAM (BITSTREAM),
        .CHANNELS  (CHANNELS),
        .KW        (KW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_k      (in_k),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   mode;
        logic [W-1:0] bits;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    int           n_out = 0;
    int           rdy_mode = 0;
    int           cyc = 0;
    logic         held = 1'b0;
    logic [W-1:0] held_bits;
    logic [1:0]   held_mode;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_lane(input logic [1:0] m, input logic [KW-1:0] k,
                                             input logic [63:0] d);
        int s;
        s = int'(k);
        case (m)
            2'd0:    return (s == 0) ? d : ((d >> s) | (d << (64 - s)));
            2'd1:    return (s == 0) ? d : ((d << s) | (d >> (64 - s)));
            2'd2:    return d >> s;
            default: return d;
        endcase
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // out_ready policy: 0 always 1, 1 pattern 1,0,0,1, 2 random, 3 held low
    always @(posedge clk) begin
        #1;
        cyc++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", W'(out_valid), W'(1));
                check("stall_bits", out_bits, held_bits);
                check("stall_mode", W'(out_mode), W'(held_mode));
            end
            held = 1'b0;
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_out", W'(out_valid), W'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_bits", out_bits, e.bits);
                    check("out_mode", W'(out_mode), W'(e.mode));
                end
            end else if (out_valid) begin
                held      = 1'b1;
                held_bits = out_bits;
                held_mode = out_mode;
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [CHANNELS*KW-1:0] k, input logic [W-1:0] d);
        exp_t e;
        e.mode = m;
        for (int c = 0; c < CHANNELS; c++)
            e.bits[c*BITSTREAM +: BITSTREAM] = ref_lane(m, k[c*KW +: KW], d[c*BITSTREAM +: BITSTREAM]);
        in_valid = 1'b1;
        in_mode  = m;
        in_k     = k;
        in_bits  = d;
        for (int t = 0; ; t++) begin
            #1;
            if (in_ready) begin
                sb.push_back(e);
                break;
            end
            if (t > 200) begin
                check("in_ready_timeout", W'(in_ready), W'(1));
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 500 && sb.size() != 0; t++) @(posedge clk);
        #2;
        check(tag, W'(sb.size()), W'(0));
    endtask

    function automatic logic [CHANNELS*KW-1:0] rand_k();
        logic [CHANNELS*KW-1:0] k;
        for (int c = 0; c < CHANNELS; c++) k[c*KW +: KW] = KW'($urandom_range(0, 63));
        return k;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]           d;
        logic [CHANNELS*KW-1:0] k;
        logic [63:0]            pat;
        int                     snap;

        #1 rst_n = 1'b0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_bits", out_bits, '0);
        check("rst_out_mode", W'(out_mode), W'(0));

        // basic ROR with latency check
        @(negedge clk);
        rst_n = 1'b1;
        d = rand_w();
        d[63:0] = 64'h0000_0000_0000_0001;
        k = rand_k();
        k[KW-1:0] = KW'(1);
        send(2'd0, k, d);
        @(negedge clk);
        check("lat_cycle1_valid", W'(out_valid), W'(0));
        @(negedge clk);
        check("lat_cycle2_valid", W'(out_valid), W'(1));
        check("basic_ror_lane0", W'(out_bits[63:0]), W'(64'h8000_0000_0000_0000));
        @(posedge clk);
        #1;

        // k=0 in ROR/ROL/BYPASS, then BYPASS with k=63
        pat = 64'hDEAD_BEEF_0123_4567;
        d = {CHANNELS{pat}};
        send(2'd0, '0, d);
        send(2'd1, '0, d);
        send(2'd3, '0, d);
        send(2'd3, {CHANNELS{6'd63}}, d);

        // SHR fill
        send(2'd2, {CHANNELS{6'd63}}, {W{1'b1}});

        // per-lane independence, ROL
        send(2'd1, {6'd63, 6'd32, 6'd1, 6'd0}, rand_w());
        drain("drain_directed");

        // backpressure
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) send(2'($urandom_range(0, 3)), rand_k(), rand_w());
        drain("drain_backpressure");
        rdy_mode = 0;

        // reset with two beats in flight
        rdy_mode = 3;
        @(posedge clk);
        #2;
        send(2'd0, rand_k(), rand_w());
        send(2'd1, rand_k(), rand_w());
        #2;
        check("pre_rst_valid", W'(out_valid), W'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_out_bits", out_bits, '0);
        sb.delete();
        snap = n_out;
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        repeat (6) @(posedge clk);
        #2;
        check("no_out_after_rst", W'(n_out), W'(snap));
        check("idle_after_rst", W'(out_valid), W'(0));
        send(2'd2, rand_k(), rand_w());
        drain("drain_after_rst");

        // random sweep
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) send(2'($urandom_range(0, 3)), rand_k(), rand_w());
        drain("drain_random");
        rdy_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
